// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the UART calculator operation scheduler.
// Holds opcode encodings, scheduler FSM states, operand/result widths and
// the parsed-command record carried through the active register and pending slot.
package calc_pkg;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [OPND_W-1:0] src1;
    logic [OPND_W-1:0] src2;
  } cmd_t;

endpackage

// File: rtl/calc_cmd_slot.sv
// calc_cmd_slot: one-entry command buffer between parser and scheduler FSM.
// Latency: a push is visible on cmd_o/full_o the cycle after it is taken.
// Backpressure: push while full (without a same-cycle pop) is dropped and drop_o pulses.
// Ports: clk/n_rst, push_i/cmd_i (write), pop_i (read), full_o/cmd_o (state), drop_o.
module calc_cmd_slot
  import calc_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic push_i,
  input  cmd_t cmd_i,
  input  logic pop_i,
  output logic full_o,
  output cmd_t cmd_o,
  output logic drop_o
);

  logic full_q, full_d;
  cmd_t cmd_q, cmd_d;

  // A pop in the same cycle frees the entry, so a simultaneous push refills it.
  always_comb begin
    full_d = full_q;
    cmd_d  = cmd_q;
    drop_o = 1'b0;
    if (pop_i) full_d = 1'b0;
    if (push_i) begin
      if (full_q && !pop_i) begin
        drop_o = 1'b1;
      end else begin
        full_d = 1'b1;
        cmd_d  = cmd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full_q <= 1'b0;
      cmd_q  <= '0;
    end else begin
      full_q <= full_d;
      cmd_q  <= cmd_d;
    end
  end

  assign full_o = full_q;
  assign cmd_o  = cmd_q;

endmodule

// File: rtl/calc_op_sched.sv
// calc_op_sched: dispatches parsed commands to the add/sub unit or multiplier.
// Latency: start pulse one cycle after parser_done; res_valid one cycle after unit done.
// Backpressure: result held until res_ready; one command buffered while busy, further ones dropped (ovf).
// Ports: parser command in (parser_done/cmd_*), unit start/operands out and done/result in,
//        result valid/ready out to TX, busy/ovf status with ovf_clr.
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              parser_done,
  input  logic [1:0]        cmd_op,
  input  logic [OPND_W-1:0] cmd_src1,
  input  logic [OPND_W-1:0] cmd_src2,
  output logic              add_start,
  output logic              add_sub,
  output logic              mul_start,
  output logic [OPND_W-1:0] unit_src1,
  output logic [OPND_W-1:0] unit_src2,
  input  logic              add_done,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  add_res,
  input  logic [RES_W-1:0]  mul_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e           state_q;
  cmd_t             act_q;
  logic [7:0]       wdog_q;
  logic             add_start_q, add_sub_q, mul_start_q;
  logic             res_valid_q, res_err_q, ovf_q;
  logic [RES_W-1:0] res_data_q;

  cmd_t             new_cmd, slot_cmd, issue_cmd;
  logic             slot_full, slot_drop, slot_push, slot_pop, issue_go;
  logic             done_hit;
  logic [RES_W-1:0] unit_res;

  assign new_cmd = '{op: op_e'(cmd_op), src1: cmd_src1, src2: cmd_src2};

  // In IDLE the buffered command wins; a same-cycle parser_done refills the slot.
  assign slot_pop  = (state_q == ST_IDLE) && slot_full;
  assign slot_push = parser_done && ((state_q != ST_IDLE) || slot_full);
  assign issue_go  = slot_full || parser_done;
  assign issue_cmd = slot_full ? slot_cmd : new_cmd;

  calc_cmd_slot u_slot (
    .clk    (clk),
    .n_rst  (n_rst),
    .push_i (slot_push),
    .cmd_i  (new_cmd),
    .pop_i  (slot_pop),
    .full_o (slot_full),
    .cmd_o  (slot_cmd),
    .drop_o (slot_drop)
  );

  // Only the unit that was dispatched may complete the command.
  assign done_hit = (act_q.op == OP_MUL) ? mul_done : add_done;
  assign unit_res = (act_q.op == OP_MUL) ? mul_res : add_res;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      act_q       <= '0;
      wdog_q      <= '0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      mul_start_q <= 1'b0;

      if (slot_drop)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (issue_go) begin
            act_q       <= issue_cmd;
            state_q     <= ST_ISSUE;
            // Start pulses are registered here so they appear in the ISSUE cycle.
            add_start_q <= (issue_cmd.op == OP_ADD) || (issue_cmd.op == OP_SUB);
            add_sub_q   <= (issue_cmd.op == OP_SUB);
            mul_start_q <= (issue_cmd.op == OP_MUL);
          end
        end
        ST_ISSUE: begin
          wdog_q <= '0;
          if (act_q.op == OP_RSV) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done_hit) begin
            res_data_q  <= unit_res;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (wdog_q == WDOG_LAST) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign add_start = add_start_q;
  assign add_sub   = add_sub_q;
  assign mul_start = mul_start_q;
  assign unit_src1 = act_q.src1;
  assign unit_src2 = act_q.src2;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_data  = res_data_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != ST_IDLE) || slot_full;

endmodule
